// File: rtl/matmul_core_pkg.sv
// rtl/matmul_core_pkg.sv - shared types and arithmetic helpers for the systolic matmul core
package matmul_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    // Helpers work in a 64-bit container so any ACC_WIDTH up to 64 can share them.
    localparam int CALC_W = 64;

    function automatic logic [CALC_W-1:0] sext(input logic [CALC_W-1:0] v, input int w);
        logic signed [CALC_W-1:0] t;
        t = $signed(v << (CALC_W - w));
        return t >>> (CALC_W - w);
    endfunction

    // Operands must already be sign-extended from width w; overflow is judged at width w.
    function automatic logic [CALC_W-1:0] sat_add(input logic [CALC_W-1:0] a,
                                                  input logic [CALC_W-1:0] b,
                                                  input int w,
                                                  input logic sat,
                                                  output logic ovf);
        logic [CALC_W-1:0] s;
        logic [CALC_W-1:0] max_v;
        s     = a + b;
        ovf   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        max_v = {CALC_W{1'b1}} >> (CALC_W - w + 1);
        if (ovf && sat) begin
            return a[w-1] ? ~max_v : max_v;
        end
        return s;
    endfunction

endpackage

// File: rtl/matmul_core_pe.sv
// rtl/matmul_core_pe.sv - one systolic processing element with sat/wrap accumulator
module matmul_core_pe
    import matmul_core_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_i,
    input  logic [ACC_WIDTH-1:0]  bias_i,
    input  logic                  run_i,
    input  logic                  en_i,
    input  logic                  sat_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic                  flag_o
);

    logic [DATA_WIDTH-1:0]         a_q, b_q;
    logic [ACC_WIDTH-1:0]          acc_q, acc_d;
    logic                          flag_q, flag_d;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]          sum;
    logic                          ovf;

    always_comb begin
        prod   = $signed(a_i) * $signed(b_i);
        ovf    = 1'b0;
        sum    = ACC_WIDTH'(sat_add(sext(CALC_W'(acc_q), ACC_WIDTH),
                                    sext(CALC_W'(prod), 2 * DATA_WIDTH),
                                    ACC_WIDTH, sat_i, ovf));
        acc_d  = acc_q;
        flag_d = flag_q;
        if (init_i) begin
            acc_d  = bias_i;
            flag_d = 1'b0;
        end else if (run_i && en_i) begin
            acc_d  = sum;
            flag_d = flag_q | ovf;
        end
    end

    // Operand registers are flushed on init so a previous run cannot leak into the new one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
            if (init_i) begin
                a_q <= '0;
                b_q <= '0;
            end else if (run_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign acc_o  = acc_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/matmul_core.sv
// rtl/matmul_core.sv - runtime-sized systolic matrix multiply engine with counter-driven skew
module matmul_core
    import matmul_core_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  MAX_DIM    = 4,
    parameter int  ACC_WIDTH  = 2 * DATA_WIDTH,
    localparam int DIM_W      = $clog2(MAX_DIM)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [DIM_W-1:0]                cfg_n_i,
    input  logic [DIM_W-1:0]                cfg_k_i,
    input  logic [DIM_W-1:0]                cfg_m_i,
    input  logic                            cfg_bias_en_i,
    input  logic                            cfg_sat_i,
    input  logic                            ld_valid_i,
    input  logic [1:0]                      ld_sel_i,
    input  logic [DIM_W-1:0]                ld_idx_i,
    input  logic [MAX_DIM*DATA_WIDTH-1:0]   ld_data_i,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    input  logic [DIM_W-1:0]                res_idx_i,
    output logic [MAX_DIM*ACC_WIDTH-1:0]    res_data_o,
    output logic [MAX_DIM-1:0]              res_flags_o
);

    localparam int CNT_W = $clog2(3 * MAX_DIM) + 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        last_cnt;
    logic                    err_q, err_d;
    logic                    start_ok, busy, ld_ok;
    logic [DIM_W-1:0]        cfg_n_q, cfg_k_q, cfg_m_q;
    logic                    bias_en_q, sat_q;

    logic [DATA_WIDTH-1:0]   a_buf_q [MAX_DIM][MAX_DIM];
    logic [DATA_WIDTH-1:0]   b_buf_q [MAX_DIM][MAX_DIM];
    logic [DATA_WIDTH-1:0]   c_buf_q [MAX_DIM][MAX_DIM];
    logic [DATA_WIDTH-1:0]   feed_a  [MAX_DIM];
    logic [DATA_WIDTH-1:0]   feed_b  [MAX_DIM];

    logic [DATA_WIDTH-1:0]   a_h  [MAX_DIM][MAX_DIM+1];
    logic [DATA_WIDTH-1:0]   b_v  [MAX_DIM+1][MAX_DIM];
    logic [ACC_WIDTH-1:0]    acc  [MAX_DIM][MAX_DIM];
    logic                    flag [MAX_DIM][MAX_DIM];

    logic [MAX_DIM*ACC_WIDTH-1:0] res_data_q;
    logic [MAX_DIM-1:0]           res_flags_q;

    // The last useful MAC is PE(N-1,M-1) at k=K-1, i.e. cnt = n+k+m on the minus-one fields.
    assign last_cnt = CNT_W'(cfg_n_q) + CNT_W'(cfg_k_q) + CNT_W'(cfg_m_q);
    assign busy     = (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_ok = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    start_ok = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == last_cnt) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ld_ok = ld_valid_i && !busy && (ld_sel_i != 2'd3);
        err_d = (ld_valid_i && (busy || ld_sel_i == 2'd3)) || ((start_i || cfg_valid_i) && busy);
    end

    // Skew: row i (column j) is fed element t-i (t-j) while inside the active K window.
    always_comb begin
        int kk;
        for (int i = 0; i < MAX_DIM; i++) begin
            feed_a[i] = '0;
            feed_b[i] = '0;
            kk = int'(cnt_q) - i;
            if (busy && kk >= 0 && kk <= int'(cfg_k_q)) begin
                if (i <= int'(cfg_n_q)) feed_a[i] = a_buf_q[i][DIM_W'(kk)];
                if (i <= int'(cfg_m_q)) feed_b[i] = b_buf_q[i][DIM_W'(kk)];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            cfg_n_q   <= '0;
            cfg_k_q   <= '0;
            cfg_m_q   <= '0;
            bias_en_q <= 1'b0;
            sat_q     <= 1'b0;
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    a_buf_q[i][j] <= '0;
                    b_buf_q[i][j] <= '0;
                    c_buf_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (cfg_valid_i && state_q == ST_IDLE) begin
                cfg_n_q   <= cfg_n_i;
                cfg_k_q   <= cfg_k_i;
                cfg_m_q   <= cfg_m_i;
                bias_en_q <= cfg_bias_en_i;
                sat_q     <= cfg_sat_i;
            end
            if (ld_ok) begin
                for (int e = 0; e < MAX_DIM; e++) begin
                    case (ld_sel_i)
                        SEL_A:   a_buf_q[ld_idx_i][e] <= ld_data_i[e*DATA_WIDTH +: DATA_WIDTH];
                        SEL_B:   b_buf_q[ld_idx_i][e] <= ld_data_i[e*DATA_WIDTH +: DATA_WIDTH];
                        SEL_C:   c_buf_q[ld_idx_i][e] <= ld_data_i[e*DATA_WIDTH +: DATA_WIDTH];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_data_q  <= '0;
            res_flags_q <= '0;
        end else begin
            for (int e = 0; e < MAX_DIM; e++) begin
                res_data_q[e*ACC_WIDTH +: ACC_WIDTH] <= acc[res_idx_i][e];
                res_flags_q[e]                       <= flag[res_idx_i][e];
            end
        end
    end

    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_edge
        assign a_h[gi][0] = feed_a[gi];
        assign b_v[0][gi] = feed_b[gi];
    end

    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
            logic                 pe_en;
            logic [ACC_WIDTH-1:0] bias;
            assign pe_en = (DIM_W'(gi) <= cfg_n_q) && (DIM_W'(gj) <= cfg_m_q);
            assign bias  = (bias_en_q && pe_en)
                         ? ACC_WIDTH'(sext(CALC_W'(c_buf_q[gi][gj]), DATA_WIDTH)) : '0;

            matmul_core_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .init_i (start_ok),
                .bias_i (bias),
                .run_i  (busy),
                .en_i   (pe_en),
                .sat_i  (sat_q),
                .a_i    (a_h[gi][gj]),
                .b_i    (b_v[gi][gj]),
                .a_o    (a_h[gi][gj+1]),
                .b_o    (b_v[gi+1][gj]),
                .acc_o  (acc[gi][gj]),
                .flag_o (flag[gi][gj])
            );
        end
    end

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign busy_o      = busy;
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;
    assign res_data_o  = res_data_q;
    assign res_flags_o = res_flags_q;

endmodule

// File: tb/tb_matmul_core.sv
// tb/tb_matmul_core.sv - scoreboard bench for matmul_core with directed matrix vectors
module tb_matmul_core;

    localparam int DW = 16;
    localparam int MD = 4;
    localparam int AW = 32;
    localparam int RW = MD * AW;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            cfg_valid_i = 1'b0;
    logic            cfg_ready_o;
    logic [1:0]      cfg_n_i = '0, cfg_k_i = '0, cfg_m_i = '0;
    logic            cfg_bias_en_i = 1'b0, cfg_sat_i = 1'b0;
    logic            ld_valid_i = 1'b0;
    logic [1:0]      ld_sel_i = '0;
    logic [1:0]      ld_idx_i = '0;
    logic [MD*DW-1:0] ld_data_i = '0;
    logic            start_i = 1'b0;
    logic            busy_o, done_o, err_o;
    logic [1:0]      res_idx_i = '0;
    logic [RW-1:0]   res_data_o;
    logic [MD-1:0]   res_flags_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [RW-1:0] data;
        logic [MD-1:0] flags;
        int            id;
    } exp_t;

    exp_t sb_q[$];
    logic rd_req = 1'b0;
    logic rd_q   = 1'b0;

    matmul_core #(.DATA_WIDTH(DW), .MAX_DIM(MD), .ACC_WIDTH(AW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_n_i       (cfg_n_i),
        .cfg_k_i       (cfg_k_i),
        .cfg_m_i       (cfg_m_i),
        .cfg_bias_en_i (cfg_bias_en_i),
        .cfg_sat_i     (cfg_sat_i),
        .ld_valid_i    (ld_valid_i),
        .ld_sel_i      (ld_sel_i),
        .ld_idx_i      (ld_idx_i),
        .ld_data_i     (ld_data_i),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .res_idx_i     (res_idx_i),
        .res_data_o    (res_data_o),
        .res_flags_o   (res_flags_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_q <= rd_req;

    always @(negedge clk) begin
        if (rd_q) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got read with no expected entry");
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("row%0d_data", e.id), res_data_o, e.data);
                chk($sformatf("row%0d_flags", e.id), RW'(res_flags_o), RW'(e.flags));
            end
        end
    end

    function automatic logic [RW-1:0] row4(input int v0, input int v1, input int v2, input int v3);
        return {32'(v3), 32'(v2), 32'(v1), 32'(v0)};
    endfunction

    function automatic logic [MD*DW-1:0] ld4(input int v0, input int v1, input int v2, input int v3);
        return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    task automatic cfg_set(input int n, input int k, input int m, input bit bias, input bit sat);
        cfg_valid_i = 1'b1;
        cfg_n_i = 2'(n); cfg_k_i = 2'(k); cfg_m_i = 2'(m);
        cfg_bias_en_i = bias; cfg_sat_i = sat;
        @(negedge clk);
        cfg_valid_i = 1'b0;
    endtask

    task automatic load(input logic [1:0] sel, input int idx, input logic [MD*DW-1:0] d);
        ld_valid_i = 1'b1; ld_sel_i = sel; ld_idx_i = 2'(idx); ld_data_i = d;
        @(negedge clk);
        ld_valid_i = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [RW-1:0] d, input logic [MD-1:0] f);
        exp_t e;
        e.data = d; e.flags = f; e.id = idx;
        sb_q.push_back(e);
        res_idx_i = 2'(idx);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic run(input string name, input int lat, input bit illegal);
        int cyc;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        chk({name, "_busy"}, RW'(busy_o), RW'(1));
        if (illegal) begin
            ld_valid_i = 1'b1; ld_sel_i = 2'd0; ld_idx_i = 2'd0; ld_data_i = {4{16'h0777}};
            @(negedge clk); cyc++;
            ld_valid_i = 1'b0;
            chk("err_ld_run", RW'(err_o), RW'(1));
            start_i = 1'b1;
            @(negedge clk); cyc++;
            start_i = 1'b0;
            chk("err_start_run", RW'(err_o), RW'(1));
            chk("cfg_ready_run", RW'(cfg_ready_o), RW'(0));
            cfg_valid_i = 1'b1; cfg_n_i = 2'd0; cfg_k_i = 2'd0; cfg_m_i = 2'd0; cfg_bias_en_i = 1'b1;
            @(negedge clk); cyc++;
            cfg_valid_i = 1'b0; cfg_bias_en_i = 1'b0;
            chk("err_cfg_run", RW'(err_o), RW'(1));
        end
        while (!done_o && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, RW'(cyc), RW'(lat));
        chk({name, "_busy_at_done"}, RW'(busy_o), RW'(0));
        @(negedge clk);
        chk({name, "_done_pulse"}, RW'(done_o), RW'(0));
        chk({name, "_ready_after"}, RW'(cfg_ready_o), RW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dseen;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_cfg_ready", RW'(cfg_ready_o), RW'(1));
        chk("rst_busy", RW'(busy_o), RW'(0));
        chk("rst_done", RW'(done_o), RW'(0));
        chk("rst_err", RW'(err_o), RW'(0));
        chk("rst_res", res_data_o, '0);

        // 2x2x2 basic product
        cfg_set(1, 1, 1, 1'b0, 1'b0);
        load(2'd0, 0, ld4(1, 2, 0, 0));
        load(2'd0, 1, ld4(3, 4, 0, 0));
        load(2'd1, 0, ld4(5, 7, 0, 0));
        load(2'd1, 1, ld4(6, 8, 0, 0));
        run("t2x2", 5, 1'b0);
        rd(0, row4(19, 22, 0, 0), 4'h0);
        rd(1, row4(43, 50, 0, 0), 4'h0);

        // reserved select pulses err and must not touch any buffer
        load(2'd3, 0, {4{16'h1234}});
        chk("err_sel3", RW'(err_o), RW'(1));

        // same buffers, illegal traffic during RUN, identical result expected
        run("t2x2_illegal", 5, 1'b1);
        rd(0, row4(19, 22, 0, 0), 4'h0);
        rd(1, row4(43, 50, 0, 0), 4'h0);

        // full 4x4x4: identity times B plus all-ones bias
        cfg_set(3, 3, 3, 1'b1, 1'b0);
        load(2'd0, 0, ld4(1, 0, 0, 0));
        load(2'd0, 1, ld4(0, 1, 0, 0));
        load(2'd0, 2, ld4(0, 0, 1, 0));
        load(2'd0, 3, ld4(0, 0, 0, 1));
        load(2'd1, 0, ld4(3, -5, 100, 9));
        load(2'd1, 1, ld4(-2, 10, -100, -9));
        load(2'd1, 2, ld4(7, 1, 2, 32767));
        load(2'd1, 3, ld4(0, 4, -1, -32768));
        for (int i = 0; i < MD; i++) load(2'd2, i, ld4(1, 1, 1, 1));
        run("t4x4", 11, 1'b0);
        rd(0, row4(4, -1, 8, 1), 4'h0);
        rd(1, row4(-4, 11, 2, 5), 4'h0);
        rd(2, row4(101, -99, 3, 0), 4'h0);
        rd(3, row4(10, -8, 32768, -32767), 4'h0);

        // non-square 1x3 times 3x2; element k=3 loaded but outside K
        cfg_set(0, 2, 1, 1'b0, 1'b0);
        load(2'd0, 0, ld4(1, 1, 1, 5));
        load(2'd1, 0, ld4(2, 2, 2, 9));
        load(2'd1, 1, ld4(-1, -1, -1, 9));
        run("t1x3x2", 5, 1'b0);
        rd(0, row4(6, -3, 0, 0), 4'h0);
        for (int i = 1; i < MD; i++) rd(i, '0, 4'h0);

        // overflow: all elements 0x7FFF, K=4, wrap then saturate
        cfg_set(3, 3, 3, 1'b0, 1'b0);
        for (int i = 0; i < MD; i++) load(2'd0, i, {4{16'h7FFF}});
        for (int i = 0; i < MD; i++) load(2'd1, i, {4{16'h7FFF}});
        run("t_wrap", 11, 1'b0);
        for (int i = 0; i < MD; i++) rd(i, {4{32'hFFFC0004}}, 4'hF);
        cfg_set(3, 3, 3, 1'b0, 1'b1);
        run("t_sat", 11, 1'b0);
        for (int i = 0; i < MD; i++) rd(i, {4{32'h7FFFFFFF}}, 4'hF);

        // reset in the middle of a run
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_busy", RW'(busy_o), RW'(1));
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_busy", RW'(busy_o), RW'(0));
        chk("abort_ready", RW'(cfg_ready_o), RW'(1));
        dseen = 0;
        for (int c = 0; c < 15; c++) begin
            if (done_o) dseen++;
            @(negedge clk);
        end
        chk("abort_no_done", RW'(dseen), RW'(0));
        for (int i = 0; i < MD; i++) rd(i, '0, 4'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", RW'(sb_q.size()), RW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_core.md
Name: matmul_core

Overview:
Parametrised next-generation systolic matrix-multiply engine. Computes C = A x B (+ bias) for runtime dimensions N x K times K x M, up to MAX_DIM. Operand skew is generated from a cycle counter, so no per-operand FIFOs are needed. Adds the following, decoupled from the bus width:
- saturating arithmetic mode
- sticky per-element overflow flags
- config/start/done handshake

Sits behind the APB register front end, which drives its load, config and read ports.

Parameters:
DATA_WIDTH, 16, operand element width, signed two's complement
MAX_DIM, 4, array side; any power of two 2..8
ACC_WIDTH, 2*DATA_WIDTH, accumulator/result element width
DIM_W, $clog2(MAX_DIM), localparam, width of the dimension fields

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_valid_i  in  1  config write strobe
cfg_ready_o  out  1  high when IDLE
cfg_n_i  in  DIM_W  rows of A minus 1
cfg_k_i  in  DIM_W  inner dimension minus 1
cfg_m_i  in  DIM_W  columns of B minus 1
cfg_bias_en_i  in  1  preload accumulators from C bias
cfg_sat_i  in  1  saturate instead of wrap
ld_valid_i  in  1  operand row load strobe
ld_sel_i  in  2  0=A row, 1=B column, 2=C bias row, 3=reserved
ld_idx_i  in  DIM_W  row/column index
ld_data_i  in  MAX_DIM*DATA_WIDTH  element e in bits [e*DATA_WIDTH +: DATA_WIDTH]
start_i  in  1  start pulse
busy_o  out  1  computation in progress
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle illegal-access pulse
res_idx_i  in  DIM_W  result row select
res_data_o  out  MAX_DIM*ACC_WIDTH  registered result row
res_flags_o  out  MAX_DIM  registered overflow flags of that row

Behaviour:
- Reset: all outputs are 0 except cfg_ready_o, which is 1. A/B/C buffers, accumulators, flags and config are cleared; FSM goes to IDLE. Reset mid-RUN aborts immediately with no done_o.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on start_i.
  - RUN->DONE when cnt == K+N+M-3, where N,K,M are dimension fields +1.
  - DONE->IDLE unconditionally.
- Config: sampled on cfg_valid_i && cfg_ready_o. Held until the next accepted write.
- Loads: accepted in IDLE or DONE.
- Illegal accesses, each pulsing err_o for one cycle:
  - ld_valid_i in RUN: ignored.
  - ld_sel_i == 3: ignored.
  - start_i while busy: ignored.
  - cfg_valid_i while busy: cfg_ready_o is 0, so it is not accepted.
- Start cycle (start_i in IDLE):
  - Accumulator (i,j) loads sign-extended C[i][j] if bias_en, else 0.
  - All flags are cleared.
  - cnt = 0.
  - busy_o rises the next cycle.
- Feeding (RUN, cycle cnt=t):
  - Row input i gets A[i][t-i] when 0<=t-i<K and i<N, else 0.
  - Column input j gets B[t-j][j] when 0<=t-j<K and j<M, else 0.
  - Operands shift one PE right/down per cycle, so PE(i,j) sees k = t-i-j.
- MAC per cycle: acc += sext(a*b), where the product is 2*DATA_WIDTH signed.
  - Signed overflow of the ACC_WIDTH add sets the sticky flag (i,j).
  - With cfg_sat_i, acc clamps to max/min signed; without it, acc wraps.
- PEs outside N x M hold 0 and never flag.
- Completion: in the DONE cycle, done_o=1 and busy_o=0; results are final.
- Latency: done_o occurs K+N+M-1 cycles after the start_i cycle.
- Read: res_data_o and res_flags_o update on the cycle after res_idx_i, at any time. During RUN they show partial sums.
- A start with unchanged buffers recomputes identically.

Decomposition:
- Package matmul_core_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - ld_sel constants SEL_A, SEL_B, SEL_C
  - functions: sat_add (returns sum and overflow) and sext
- One sub-module, matmul_core_pe:
  - operand pass-through registers
  - accumulator with sat/wrap
  - sticky flag
  - init input (bias value, init strobe)

Test Plan:
- 2x2x2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], no bias -> rows [19,22],[43,50], flags 0; done_o 5 cycles after start.
- MAX_DIM full (4x4x4), A=identity, B=random, bias_en with C=all 1 -> result B+1 element-wise; done_o 11 cycles after start.
- Non-square N=1,K=3,M=2, A=[1,1,1], B cols [2,2,2],[-1,-1,-1] -> row0=[6,-3], rows 1..3 = 0.
- DATA_WIDTH=16, K=4, all A/B elements 0x7FFF:
  - wrap mode -> flag(0,0)=1, value wrapped.
  - sat mode -> 0x7FFFFFFF, flag=1.
- Illegal traffic during RUN (ld_valid_i, start_i, cfg_valid_i) -> err_o pulse each, buffers/config unchanged, result identical to clean run.
- rst_i asserted mid-RUN -> next cycle busy_o=0, no done_o, all results 0, cfg_ready_o=1.
